if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP, default 32'h0000_0013, meaning the instruction word presented while the output is invalid.
REQ-003 SHALL use one clock and an asynchronous active-low reset: port clk (input, 1 bit, rising-edge clock) and port rst_n (input, 1 bit, async active-low reset).
REQ-004 SHALL have port stall: input, 1 bit, hold the IF/ID output and suppress new requests.
REQ-005 SHALL have port redirect: input, 1 bit, branch/jump taken and flush.
REQ-006 SHALL have port redirect_pc: input, 32 bits, redirect target.
REQ-007 SHALL have port imem_req: output, 1 bit, fetch request to the instruction memory.
REQ-008 SHALL have port imem_addr: output, 10 bits, word index equal to fetch-PC[11:2].
REQ-009 SHALL have port imem_instr_valid: input, 1 bit, memory response valid, arriving 1 cycle after imem_req.
REQ-010 SHALL have port imem_instr: input, 32 bits, memory response word.
REQ-011 SHALL have port id_valid: output, 1 bit, IF/ID register valid.
REQ-012 SHALL have port id_pc: output, 32 bits, PC of id_instr.
REQ-013 SHALL have port id_instr: output, 32 bits, fetched instruction.
REQ-014 SHALL have port misalign_err: output, 1 bit, one-cycle pulse indicating the redirect target had bits [1:0] nonzero.

Function
REQ-015 SHALL hold pc_q (next sequential fetch PC), inflight_pc (PC of the request issued last cycle), run_q, and a one-entry hold buffer (hold_v, hold_pc, hold_instr).
REQ-016 SHALL drive imem_req = run_q AND (redirect OR NOT stall); run_q SHALL be 0 in reset and 1 from the first clk edge after rst_n deasserts.
REQ-017 SHALL compute fetch-PC as {redirect_pc[31:2],2'b00} when redirect is 1, else pc_q, and drive imem_addr = fetch-PC[11:2] combinationally.
REQ-018 SHALL, on each cycle where imem_req is 1, set pc_q <= fetch-PC + 4 (mod 2^32) and inflight_pc <= fetch-PC; otherwise pc_q and inflight_pc SHALL hold.
REQ-019 SHALL, in the normal case (no redirect, no stall), update id_valid <= imem_instr_valid OR hold_v, with id_pc/id_instr taken from the hold buffer if hold_v is 1, else from inflight_pc and imem_instr.
REQ-020 SHALL, in the normal case, clear hold_v when the hold buffer is drained.
REQ-021 SHALL set id_instr <= NOP whenever id_valid is loaded 0.
REQ-022 SHALL, under stall without redirect, hold id_* unchanged, and when imem_instr_valid is 1 capture {inflight_pc, imem_instr} into the hold buffer with hold_v <= 1; at most one entry SHALL ever be pending.
REQ-023 SHALL give redirect priority over stall: on redirect, id_valid <= 0, hold_v <= 0, the response visible this cycle is discarded, and the target request is issued in the same cycle.
REQ-024 SHALL give a redirect a 1-bubble penalty, with the target instruction valid at id_* 2 edges after the redirect cycle.
REQ-025 SHALL register misalign_err <= redirect AND (redirect_pc[1:0] != 0) for exactly one cycle, and SHALL still fetch the aligned target.
REQ-026 SHALL wrap imem_addr from 1023 to 0 when fetch-PC crosses 0x1000, while id_pc continues with full 32-bit PC values.
REQ-027 SHALL never deliver any instruction twice or skip any sequential instruction across any stall pattern.
REQ-028 SHALL have a latency of 2 edges from imem_req to id_valid.

Reset
REQ-029 SHALL set, while rst_n is 0 (asynchronously): pc_q = RESET_PC, inflight_pc = RESET_PC, run_q = 0, hold_v = 0, id_valid = 0, id_pc = 0, id_instr = NOP, misalign_err = 0; imem_req SHALL be 0.
REQ-030 SHALL, on reset asserted mid-stall with hold_v = 1, discard the held entry, and after release restart at RESET_PC.

Structure
REQ-031 SHALL place NOP_INSTR, RESET_PC default, and IMEM_AW = 10 in shared package rv32_pkg.
REQ-032 SHALL use one sub-module, if_hold_buf (one-entry skid holding pc/instr/valid); all other logic SHALL be inline.

Verification (ROM[0..4] = 00000013, 002081B3, 00F0C093, 0020E663, 12345097)
REQ-033 SHALL verify reset release with no stall -> imem_addr 0,1,2 on consecutive cycles; id_valid first high 2 edges after the first request with id_pc 0x0 / id_instr 00000013, then 0x4 / 002081B3.
REQ-034 SHALL verify a 3-cycle stall asserted while the response for PC 0x8 is visible -> id_* held, imem_req 0; on release id shows 0x8 / 00F0C093 then 0xC / 0020E663, with no duplicates or gaps.
REQ-035 SHALL verify redirect to 0x10 -> id_valid 0 for 1 cycle, then id_pc 0x10 / id_instr 12345097.
REQ-036 SHALL verify redirect to 0x0000000A -> misalign_err high 1 cycle, imem_addr 2, id_pc 0x8.
REQ-037 SHALL verify redirect to 0xFFC with stall also high -> redirect wins; imem_addr 1023 then 0; id_pc 0xFFC then 0x1000.
REQ-038 SHALL verify rst_n pulled low mid-stall with hold_v = 1 -> all outputs at reset values immediately, and the first id_pc after release is RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared constants and helpers for the RV32 front end
package rv32_pkg;

    // Instruction memory word-address width (4 KiB of instruction words)
    localparam int IMEM_AW = 10;

    // Canonical RV32I NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default first fetch address after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Force a PC onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - one-entry skid buffer for a fetch response caught during a stall
module if_hold_buf
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Flush beats load; a load in the same cycle as a drain refills the entry
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage; reset discards any pending entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with stall hold buffer and redirect flush
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_instr_valid,
    input  logic [31:0]        imem_instr,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_instr,
    output logic               misalign_err
);

    logic        run_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_pc;

    logic        hold_v;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        hold_load;
    logic        hold_drain;

    // Request generation: a redirect fetches its target even while stalled
    always_comb begin
        fetch_pc      = redirect ? align_word(redirect_pc) : pc_q;
        imem_req      = run_q & (redirect | ~stall);
        imem_addr     = fetch_pc[IMEM_AW+1:2];
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        if (imem_req) begin
            pc_d          = fetch_pc + 32'd4;
            inflight_pc_d = fetch_pc;
        end
        misalign_d = redirect & (redirect_pc[1:0] != 2'b00);
    end

    // Park a response that cannot advance: during a stall, or behind an older held entry
    always_comb begin
        hold_load  = ~redirect & imem_instr_valid & (stall | hold_v);
        hold_drain = ~redirect & ~stall & hold_v;
    end

    // IF/ID next state: redirect flushes, stall freezes, otherwise oldest instruction first
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (redirect) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP;
        end else if (!stall) begin
            if (hold_v) begin
                id_valid_d = 1'b1;
                id_pc_d    = hold_pc;
                id_instr_d = hold_instr;
            end else if (imem_instr_valid) begin
                id_valid_d = 1'b1;
                id_pc_d    = inflight_pc_q;
                id_instr_d = imem_instr;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP;
            end
        end
    end

    // Fetch and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'h0;
            id_instr_q    <= NOP;
            misalign_q    <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            misalign_q    <= misalign_d;
        end
    end

    if_hold_buf u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .load_i  (hold_load),
        .drain_i (hold_drain),
        .pc_i    (inflight_pc_q),
        .instr_i (imem_instr),
        .valid_o (hold_v),
        .pc_o    (hold_pc),
        .instr_o (hold_instr)
    );

    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_instr     = id_instr_q;
    assign misalign_err = misalign_q;

endmodule
